// File: rtl/wshb_ram_slave.sv
// Wishbone B4 RAM responder: DEPTH x 32-bit RAM, programmable wait states, classic and incrementing bursts.
// Optional: define WSHB_RAM_ERR_EN to answer out-of-range beats (adr >= 4*DEPTH) with err instead of ack.
`timescale 1ns/1ps
module wshb_ram_slave #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2,
   parameter int ADR_W       = 32
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             cyc,
   input  logic             stb,
   input  logic             we,
   input  logic [ADR_W-1:0] adr,
   input  logic [31:0]      dat_ms,
   input  logic [3:0]       sel,
   input  logic [2:0]       cti,
   input  logic [1:0]       bte,
   output logic [31:0]      dat_sm,
   output logic             ack,
   output logic             err,
   output logic             rty
);

   localparam int AW = $clog2(DEPTH);
`ifdef WSHB_RAM_ERR_EN
   localparam int WA_W = ADR_W - 2;
`else
   localparam int WA_W = AW;
`endif
   localparam logic [3:0] WS_LAST  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
   localparam logic [2:0] CTI_INCR = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [WA_W-1:0] wadr_q, wadr_d, wadr_nxt, rd_wadr, adr_word;
   logic            ack_q, ack_d, err_q, err_d;
   logic [31:0]     dat_q, dat_d, rd_data;
   logic            req, beat, rd_oob, load;
   logic            unused_adr;
   logic [31:0]     mem [DEPTH];

   assign req      = cyc & stb;
   assign beat     = req & (ack_q | err_q);
   assign adr_word = adr[2 +: WA_W];

`ifdef WSHB_RAM_ERR_EN
   assign rd_oob     = rd_wadr[WA_W-1:AW] != '0;
   assign unused_adr = ^adr[1:0];
`else
   assign rd_oob     = 1'b0;
   assign unused_adr = ^{adr[ADR_W-1:AW+2], adr[1:0]};
`endif

   // Wrapping bursts advance only the low log2(N) word bits; the rest is held.
   always_comb begin
      wadr_nxt = wadr_q + WA_W'(1);
      case (bte)
         2'b01:   wadr_nxt = {wadr_q[WA_W-1:2], wadr_q[1:0] + 2'd1};
         2'b10:   wadr_nxt = {wadr_q[WA_W-1:3], wadr_q[2:0] + 3'd1};
         2'b11:   wadr_nxt = {wadr_q[WA_W-1:4], wadr_q[3:0] + 4'd1};
         default: ;
      endcase
   end

   // Address whose data is loaded into dat_q when the next response is armed.
   always_comb begin
      case (state_q)
         IDLE:    rd_wadr = adr_word;
         BURST:   rd_wadr = wadr_nxt;
         default: rd_wadr = wadr_q;
      endcase
   end

   assign rd_data = mem[rd_wadr[AW-1:0]];

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wadr_d  = wadr_q;
      ack_d   = ack_q;
      err_d   = err_q;
      dat_d   = dat_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               wadr_d = adr_word;
               cnt_d  = 4'd0;
               if (WAIT_STATES == 0) load = 1'b1;
               else                  state_d = WAIT;
            end
         end
         WAIT: begin
            if (!cyc)                  state_d = IDLE;
            else if (cnt_q == WS_LAST) load = 1'b1;
            else                       cnt_d = cnt_q + 4'd1;
         end
         ACK: begin
            if (beat || !cyc) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         BURST: begin
            if (beat && !err_q && cti == CTI_INCR) begin
               wadr_d = wadr_nxt;
               load   = 1'b1;
            end else if (beat || !cyc) begin
               state_d = IDLE;
               ack_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         ack_d   = !rd_oob;
         err_d   = rd_oob;
         dat_d   = rd_oob ? 32'd0 : rd_data;
         state_d = (cti == CTI_INCR) ? BURST : ACK;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wadr_q  <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wadr_q  <= wadr_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   // NOTE: the RAM array has no reset; clearing it would defeat RAM inference and is not needed.
   always_ff @(posedge sys_clk) begin
      if (req && ack_q && we) begin
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) mem[wadr_q[AW-1:0]][8*i +: 8] <= dat_ms[8*i +: 8];
         end
      end
   end

   assign ack    = ack_q & req;
   assign err    = err_q & req;
   assign dat_sm = dat_q;
   assign rty    = 1'b0;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Scoreboard bench for wshb_ram_slave: bus tasks push expected responses, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_wshb_ram_slave;

   localparam int DEPTH = 1024;
   localparam int WS    = 2;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        cyc, stb, we, ack, err, rty;
   logic [31:0] adr, dat_ms, dat_sm;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;

   int total = 0;
   int bad = 0;
   int cycle_cnt = 0;

   typedef struct {
      logic        is_err;
      logic        chk_data;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] bd [4];

   wshb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS), .ADR_W(32)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms), .sel(sel),
      .cti(cti), .bte(bte), .dat_sm(dat_sm), .ack(ack), .err(err), .rty(rty)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cycle_cnt);
      end
   endtask

   task automatic expect_resp(input logic is_err, input logic chk, input logic [31:0] d, input int c);
      exp_t e;
      e.is_err   = is_err;
      e.chk_data = chk;
      e.data     = d;
      e.cyc      = c;
      sb.push_back(e);
   endtask

   // Monitor: every presented ack/err must match the oldest expected response.
   always @(negedge sys_clk) begin
      if (!sys_rst && (ack || err)) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'({ack, err}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("resp_kind", 32'({ack, err}), 32'({~mon_e.is_err, mon_e.is_err}));
            check("resp_cycle", cycle_cnt, mon_e.cyc);
            if (mon_e.chk_data) check("read_data", dat_sm, mon_e.data);
            if (mon_e.is_err)   check("err_data", dat_sm, 32'd0);
         end
      end
   end

   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_ms = '0;
      sel = 4'h0; cti = CTI_CLASSIC; bte = 2'b00;
   endtask

   task automatic wait_resp();
      exp_t drop;
      for (int k = 0; k < 40; k++) begin
         @(negedge sys_clk);
         if (ack || err) return;
      end
      total++;
      bad++;
      $display("FAIL resp_timeout: no ack/err within 40 cycles (cycle %0d)", cycle_cnt);
      if (sb.size() != 0) drop = sb.pop_front();
   endtask

   task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_d, input logic exp_err);
      @(posedge sys_clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s; cti = CTI_CLASSIC; bte = 2'b00;
      expect_resp(exp_err, !w && !exp_err, exp_d, cycle_cnt + WS + 1);
      wait_resp();
      @(posedge sys_clk); #1;
      bus_idle();
   endtask

   function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] b);
      logic [31:0] n;
      n = a + 32'd4;
      case (b)
         2'b01:   n = {a[31:4], n[3:0]};
         2'b10:   n = {a[31:5], n[4:0]};
         2'b11:   n = {a[31:6], n[5:0]};
         default: ;
      endcase
      return n;
   endfunction

   // Beats numbered 1..n; stall_after/drop_after = 0 disables that event.
   task automatic burst(input logic w, input logic [31:0] a0, input logic [1:0] b, input int n,
                        input logic [31:0] d [4], input int stall_after, input int drop_after);
      logic [31:0] a;
      a = a0;
      @(posedge sys_clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; bte = b; adr = a; dat_ms = d[0];
      cti = (n == 1) ? CTI_END : CTI_INCR;
      expect_resp(1'b0, !w, d[0], cycle_cnt + WS + 1);
      for (int i = 1; i <= n; i++) begin
         wait_resp();
         @(posedge sys_clk); #1;
         if (i == n || i == drop_after) break;
         if (i == stall_after) begin
            stb = 1'b0;
            repeat (2) @(posedge sys_clk);
            #1;
            stb = 1'b1;
         end
         a = next_adr(a, b);
         adr = a; dat_ms = d[i];
         cti = (i + 1 == n) ? CTI_END : CTI_INCR;
         expect_resp(1'b0, !w, d[i], cycle_cnt);
      end
      bus_idle();
   endtask

   initial begin
      bus_idle();
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rty", 32'(rty), 32'd0);
      check("rst_dat", dat_sm, 32'd0);
      sys_rst = 1'b0;

      // Classic write/read with full latency.
      classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
      classic(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

      // Byte lanes.
      classic(1'b1, 32'h14, 32'h11223344, 4'hF, 32'h0, 1'b0);
      classic(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
      classic(1'b0, 32'h14, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);

      // Linear write burst then read burst over words 8..11.
      bd = '{32'd1, 32'd2, 32'd3, 32'd4};
      burst(1'b1, 32'h20, 2'b00, 4, bd, 0, 0);
      burst(1'b0, 32'h20, 2'b00, 4, bd, 0, 0);

      // Wrap-4 read starting at word 14.
      classic(1'b1, 32'h30, 32'h00000A12, 4'hF, 32'h0, 1'b0);
      classic(1'b1, 32'h34, 32'h00000A13, 4'hF, 32'h0, 1'b0);
      classic(1'b1, 32'h38, 32'h00000A14, 4'hF, 32'h0, 1'b0);
      classic(1'b1, 32'h3C, 32'h00000A15, 4'hF, 32'h0, 1'b0);
      bd = '{32'h00000A14, 32'h00000A15, 32'h00000A12, 32'h00000A13};
      burst(1'b0, 32'h38, 2'b01, 4, bd, 0, 0);

      // Stall after beat 2, cyc dropped after beat 3; then a normal classic read.
      bd = '{32'd1, 32'd2, 32'd3, 32'd4};
      burst(1'b0, 32'h20, 2'b00, 4, bd, 2, 3);
      repeat (4) @(posedge sys_clk);
      classic(1'b0, 32'h24, 32'h0, 4'hF, 32'd2, 1'b0);

      // Reset during WAIT of a write: no ack, no write.
      @(posedge sys_clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_ms = 32'h55555555; sel = 4'hF; cti = CTI_CLASSIC;
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      #1;
      check("rst_wait_ack", 32'(ack), 32'd0);
      bus_idle();
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      classic(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

      // Reset while a burst beat is being acked: outputs clear immediately.
      @(posedge sys_clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 4'hF; cti = CTI_INCR; bte = 2'b00;
      expect_resp(1'b0, 1'b1, 32'd1, cycle_cnt + WS + 1);
      wait_resp();
      #1;
      sys_rst = 1'b1;
      #1;
      check("rst_burst_ack", 32'(ack), 32'd0);
      check("rst_burst_dat", dat_sm, 32'd0);
      bus_idle();
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;

      // sel=0 acks without writing.
      classic(1'b1, 32'h10, 32'h00000000, 4'h0, 32'h0, 1'b0);
      classic(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

      // Beyond 4*DEPTH: error response, or alias onto word 4 without the feature.
`ifdef WSHB_RAM_ERR_EN
      classic(1'b0, 32'h1010, 32'h0, 4'hF, 32'h0, 1'b1);
`else
      classic(1'b0, 32'h1010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
`endif

      repeat (3) @(posedge sys_clk);
      #1;
      check("sb_drained", sb.size(), 32'd0);
      check("rty_zero", 32'(rty), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
